// File: rtl/silent_div_arbiter.sv
// silent_div_arbiter: round-robin front end that lets NUM_REQ requesters share
// one fixed-latency divider. Each requester may have one operation in flight;
// a tag pipeline shadows the divider so the remainder is routed back to the
// requester that issued it. Zero divisors never reach the divider and are
// answered with RESP_ERR instead.
module silent_div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 68
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [64*NUM_REQ-1:0] REQ_DIVIDEND,
  input  logic [16*NUM_REQ-1:0] REQ_DIVISOR,
  output logic [63:0]           DIV_DIVIDEND,
  output logic [15:0]           DIV_DIVISOR,
  output logic                  DIV_VALID,
  input  logic [15:0]           DIV_REM,
  output logic [NUM_REQ-1:0]    RESP_VALID,
  output logic [15:0]           RESP_REM,
  output logic                  RESP_ERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-requester operand views of the flat input buses.
  logic [63:0] req_dvd [NUM_REQ];
  logic [15:0] req_dvs [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_dvd[gi] = REQ_DIVIDEND[64*gi +: 64];
      assign req_dvs[gi] = REQ_DIVISOR[16*gi +: 16];
    end
  endgenerate

  // Arbitration state.
  logic [NUM_REQ-1:0] busy_reg;
  logic [NUM_REQ-1:0] busy_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_vec;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               grant_found;
  logic               accept;
  logic               grant_err;

  // Issue stage: tag travelling with the operands presented to the divider.
  logic               issue_valid_reg;
  logic               issue_err_reg;
  logic [IDX_W-1:0]   issue_idx_reg;

  // Tag pipeline, one stage per divider latency cycle.
  logic [DIV_LATENCY-1:0] pipe_valid_reg;
  logic [DIV_LATENCY-1:0] pipe_err_reg;
  logic [IDX_W-1:0]       pipe_idx_reg [DIV_LATENCY];

  logic               tail_valid;
  logic               tail_err;
  logic [IDX_W-1:0]   tail_idx;

  // Round-robin search starting just after the last granted requester. A
  // requester whose response is being delivered this cycle is already free.
  always_comb begin
    eligible    = REQ_VALID & (~busy_reg | RESP_VALID);
    grant_vec   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    // Ready is combinational, so hold it low explicitly while in reset.
    if (grant_found && RST_N) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign REQ_READY = grant_vec;
  assign accept    = |grant_vec;
  assign grant_err = (req_dvs[grant_idx] == 16'd0);
  assign busy_next = (busy_reg & ~RESP_VALID) | grant_vec;

  // Capture operands and tag on accept; zero divisors bypass the divider.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_reg  <= IDX_W'(NUM_REQ - 1);
      busy_reg        <= '0;
      DIV_VALID       <= 1'b0;
      DIV_DIVIDEND    <= '0;
      DIV_DIVISOR     <= '0;
      issue_valid_reg <= 1'b0;
      issue_err_reg   <= 1'b0;
      issue_idx_reg   <= '0;
    end else begin
      busy_reg        <= busy_next;
      DIV_VALID       <= accept && !grant_err;
      issue_valid_reg <= accept;
      issue_err_reg   <= accept && grant_err;
      issue_idx_reg   <= grant_idx;
      if (accept) begin
        last_grant_reg <= grant_idx;
        DIV_DIVIDEND   <= req_dvd[grant_idx];
        DIV_DIVISOR    <= req_dvs[grant_idx];
      end
    end
  end

  // Shift tags alongside the divider so the tail lines up with DIV_REM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_valid_reg <= '0;
      pipe_err_reg   <= '0;
      for (int s = 0; s < DIV_LATENCY; s++) begin
        pipe_idx_reg[s] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= issue_valid_reg;
      pipe_err_reg[0]   <= issue_err_reg;
      pipe_idx_reg[0]   <= issue_idx_reg;
      for (int s = 1; s < DIV_LATENCY; s++) begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_err_reg[s]   <= pipe_err_reg[s-1];
        pipe_idx_reg[s]   <= pipe_idx_reg[s-1];
      end
    end
  end

  assign tail_valid = pipe_valid_reg[DIV_LATENCY-1];
  assign tail_err   = pipe_err_reg[DIV_LATENCY-1];
  assign tail_idx   = pipe_idx_reg[DIV_LATENCY-1];

  // Register the remainder and raise a one-cycle strobe for its owner.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RESP_VALID <= '0;
      RESP_REM   <= '0;
      RESP_ERR   <= 1'b0;
    end else begin
      RESP_VALID <= '0;
      RESP_REM   <= '0;
      RESP_ERR   <= 1'b0;
      if (tail_valid) begin
        RESP_VALID[tail_idx] <= 1'b1;
        RESP_REM             <= tail_err ? 16'd0 : DIV_REM;
        RESP_ERR             <= tail_err;
      end
    end
  end

endmodule

// File: tb/tb_silent_div_arbiter.sv
// Directed bench for silent_div_arbiter: a behavioural fixed-latency divider
// feeds DIV_REM, accepts push expected results into a scoreboard queue and
// responses pop and compare them, including the cycle they must arrive in.
module tb_silent_div_arbiter;

  localparam int N = 4;
  localparam int L = 68;

  logic              CLK;
  logic              RST_N;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      REQ_READY;
  logic [64*N-1:0]   req_dividend;
  logic [16*N-1:0]   req_divisor;
  logic [63:0]       DIV_DIVIDEND;
  logic [15:0]       DIV_DIVISOR;
  logic              DIV_VALID;
  logic [15:0]       DIV_REM;
  logic [N-1:0]      RESP_VALID;
  logic [15:0]       RESP_REM;
  logic              RESP_ERR;

  silent_div_arbiter #(.NUM_REQ(N), .DIV_LATENCY(L)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .REQ_VALID    (req_valid),
    .REQ_READY    (REQ_READY),
    .REQ_DIVIDEND (req_dividend),
    .REQ_DIVISOR  (req_divisor),
    .DIV_DIVIDEND (DIV_DIVIDEND),
    .DIV_DIVISOR  (DIV_DIVISOR),
    .DIV_VALID    (DIV_VALID),
    .DIV_REM      (DIV_REM),
    .RESP_VALID   (RESP_VALID),
    .RESP_REM     (RESP_REM),
    .RESP_ERR     (RESP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural divider: result appears L cycles after DIV_VALID. Idle
  // slots carry a recognisable junk value that must never reach RESP_REM.
  // It ignores reset so in-flight results still arrive afterwards.
  logic [15:0] rem_pipe [L];
  always @(posedge CLK) begin
    rem_pipe[0] <= (DIV_VALID && DIV_DIVISOR != 16'd0) ?
                   16'(DIV_DIVIDEND % {48'd0, DIV_DIVISOR}) : 16'hDEAD;
    for (int i = 1; i < L; i++) rem_pipe[i] <= rem_pipe[i-1];
  end
  assign DIV_REM = rem_pipe[L-1];

  typedef struct {
    int          idx;
    logic [15:0] rem;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t got;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input logic [63:0] dvd, input logic [15:0] dvs);
    req_dividend[64*i +: 64] = dvd;
    req_divisor[16*i +: 16]  = dvs;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Scoreboard: pop/compare responses, then push newly accepted requests.
  always @(negedge CLK) begin
    if (RST_N) begin
      check("ready_onehot", 64'($countones(REQ_READY) <= 1), 64'd1);
      if (RESP_VALID != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 64'(RESP_VALID), 64'd0);
        end else begin
          got = sb_q.pop_front();
          check("resp_valid", 64'(RESP_VALID), 64'(1 << got.idx));
          check("resp_rem",   64'(RESP_REM),   64'(got.rem));
          check("resp_err",   64'(RESP_ERR),   64'(got.err));
          check("resp_cycle", 64'(cyc),        64'(got.cyc));
          $display("[TB] resp req %0d rem %0h err %0b cycle %0d", got.idx, RESP_REM, RESP_ERR, cyc);
        end
      end else begin
        check("idle_resp_zero", {47'd0, RESP_ERR, RESP_REM}, 64'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && REQ_READY[i]) begin
          exp_t e;
          logic [63:0] dvd;
          logic [15:0] dvs;
          dvd   = req_dividend[64*i +: 64];
          dvs   = req_divisor[16*i +: 16];
          e.idx = i;
          e.err = (dvs == 16'd0);
          e.rem = (dvs == 16'd0) ? 16'd0 : 16'(dvd % {48'd0, dvs});
          e.cyc = cyc + L + 2;
          sb_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int early;
    int seen;

    RST_N        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) tick();

    // Reset state, with all requesters pushing to prove ready is held low.
    req_valid = '1;
    sample();
    check("rst_ready",    64'(REQ_READY),    64'd0);
    check("rst_div_valid",64'(DIV_VALID),    64'd0);
    check("rst_resp",     64'(RESP_VALID),   64'd0);
    check("rst_rem_err",  {47'd0, RESP_ERR, RESP_REM}, 64'd0);
    check("rst_dividend", DIV_DIVIDEND,      64'd0);
    check("rst_divisor",  64'(DIV_DIVISOR),  64'd0);
    tick();
    req_valid = '0;
    RST_N     = 1'b1;

    // Single request 100/7 from requester 2.
    tick();
    set_req(2, 64'd100, 16'd7);
    req_valid = 4'b0100;
    sample();
    check("single_ready", 64'(REQ_READY), 64'b0100);
    tick();
    req_valid = '0;
    set_req(2, 64'd999, 16'd3);
    sample();
    check("single_div_valid", 64'(DIV_VALID),   64'd1);
    check("single_dividend",  DIV_DIVIDEND,     64'd100);
    check("single_divisor",   64'(DIV_DIVISOR), 64'd7);
    tick();
    sample();
    check("single_div_pulse", 64'(DIV_VALID),   64'd0);
    check("single_hold",      DIV_DIVIDEND,     64'd100);
    drain(100);

    // Zero divisor from requester 1.
    tick();
    set_req(1, 64'd5, 16'd0);
    req_valid = 4'b0010;
    sample();
    check("zero_ready", 64'(REQ_READY), 64'b0010);
    tick();
    req_valid = '0;
    sample();
    check("zero_div_valid", 64'(DIV_VALID), 64'd0);
    drain(100);

    // All four valid out of reset: accepts 0,1,2,3 back to back.
    RST_N = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 64'(1000 + i * 37), 16'(3 + i));
    req_valid = '1;
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < N; i++) begin
      sample();
      check("rr_ready", 64'(REQ_READY), 64'(1 << i));
      tick();
    end
    sample();
    check("rr_all_busy", 64'(REQ_READY), 64'd0);
    tick();
    req_valid = '0;
    drain(100);

    // Requester 0 held valid: re-accepted exactly when its response shows.
    tick();
    set_req(0, 64'd1000, 16'd3);
    req_valid = 4'b0001;
    sample();
    check("hold_first_ready", 64'(REQ_READY), 64'b0001);
    tick();
    set_req(0, 64'd1001, 16'd3);
    early = 0;
    for (int k = 1; k <= L + 1; k++) begin
      sample();
      if (REQ_READY[0]) early++;
      tick();
    end
    check("hold_no_early_ready", 64'(early), 64'd0);
    sample();
    check("hold_reaccept_ready", 64'(REQ_READY),  64'b0001);
    check("hold_reaccept_resp",  64'(RESP_VALID), 64'b0001);
    tick();
    req_valid = '0;
    drain(100);

    // Reset 30 cycles after an accept discards the in-flight operation.
    tick();
    set_req(3, 64'd77, 16'd10);
    req_valid = 4'b1000;
    sample();
    check("rst_flight_ready", 64'(REQ_READY), 64'b1000);
    tick();
    req_valid = '0;
    repeat (29) tick();
    RST_N = 1'b0;
    sb_q.delete();
    tick();
    RST_N = 1'b1;
    seen = 0;
    repeat (200) begin
      sample();
      if (RESP_VALID != '0) seen++;
      tick();
    end
    check("rst_flight_silent", 64'(seen), 64'd0);

    // After reset requester 0 wins first, then requester 2.
    set_req(0, 64'd50, 16'd6);
    set_req(2, 64'd81, 16'd8);
    req_valid = 4'b0101;
    sample();
    check("post_rst_ready0", 64'(REQ_READY), 64'b0001);
    tick();
    sample();
    check("post_rst_ready2", 64'(REQ_READY), 64'b0100);
    tick();
    req_valid = '0;
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
